// File: rtl/apb_requester_if.sv
// Bundle of command, response and APB signals around the APB requester.
// master = requester side; slave = command source plus APB completer side.
interface apb_requester_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned WAIT_WIDTH = 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_strb;
  logic [2:0]            cmd_prot;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [WAIT_WIDTH-1:0] rsp_wait;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic [2:0]            PPROT;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_wait,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_wait,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_requester.sv
// APB4 requester: turns a valid/ready command stream into IDLE->SETUP->ACCESS
// transfers and returns a one-cycle response pulse per completed transfer.
module apb_requester #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_requester_if.master  bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned WAIT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  accept;
  logic                  complete;
  logic [WAIT_WIDTH-1:0] wait_cnt;

  // Next state and the combinational handshake; reset forces cmd_ready low.
  always_comb begin
    state_next    = state;
    bus.cmd_ready = 1'b0;
    complete      = 1'b0;
    case (state)
      IDLE:   bus.cmd_ready = !PRESET;
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          complete      = 1'b1;
          bus.cmd_ready = !PRESET;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    accept = bus.cmd_valid && bus.cmd_ready;
    if (accept) begin
      state_next = SETUP;
    end
  end

  // State register plus all registered APB and response outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.PSTRB     <= '0;
      bus.PPROT     <= '0;
      wait_cnt      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_wait  <= '0;
    end else begin
      state       <= state_next;
      bus.PSEL    <= (state_next != IDLE);
      bus.PENABLE <= (state_next == ACCESS);

      // Address-phase fields change only at accept; reads drive no data/strobes.
      if (accept) begin
        bus.PADDR  <= bus.cmd_addr;
        bus.PWRITE <= bus.cmd_write;
        bus.PPROT  <= bus.cmd_prot;
        bus.PWDATA <= bus.cmd_write ? bus.cmd_wdata : DATA_WIDTH'(0);
        bus.PSTRB  <= bus.cmd_write ? bus.cmd_strb  : STRB_WIDTH'(0);
        wait_cnt   <= '0;
      end else if (state == ACCESS && !bus.PREADY && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
      end

      bus.rsp_valid <= complete;
      if (complete) begin
        bus.rsp_rdata <= bus.PWRITE ? DATA_WIDTH'(0) : bus.PRDATA;
        bus.rsp_err   <= bus.PSLVERR;
        bus.rsp_wait  <= wait_cnt;
      end
    end
  end
endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: each scenario task drives stimulus on the
// falling edge and checks outputs on the following falling edge.
module tb_apb_requester;
  logic PCLK;
  logic PRESET;
  int   tests;
  int   fails;

  apb_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    bus.cmd_prot  = prot;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    tick();
    tick();
    tests++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) begin fails++;
      $display("FAIL reset_ctrl: got psel=%0b penable=%0b want 0/0", bus.PSEL, bus.PENABLE); end
    tests++; if (bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0 || bus.PSTRB !== 4'h0 ||
                 bus.PPROT !== 3'h0 || bus.PWRITE !== 1'b0) begin fails++;
      $display("FAIL reset_apb: got addr=%h wdata=%h strb=%h prot=%h wr=%0b want all 0",
               bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT, bus.PWRITE); end
    tests++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0 ||
                 bus.rsp_wait !== 8'h0) begin fails++;
      $display("FAIL reset_rsp: got v=%0b rdata=%h err=%0b wait=%0d want all 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_wait); end
    tests++; if (bus.cmd_ready !== 1'b0) begin fails++;
      $display("FAIL reset_ready: got %0b want 0", bus.cmd_ready); end
    PRESET = 1'b0;
    #1;
    tests++; if (bus.cmd_ready !== 1'b1) begin fails++;
      $display("FAIL idle_ready: got %0b want 1", bus.cmd_ready); end
  endtask

  task automatic test_single_write();
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hAAAA5555;
    drive_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
    tick();
    bus.cmd_valid = 1'b0;
    tests++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0 || bus.cmd_ready !== 1'b0) begin fails++;
      $display("FAIL wr_setup: got psel=%0b pen=%0b rdy=%0b want 1/0/0", bus.PSEL, bus.PENABLE, bus.cmd_ready); end
    tests++; if (bus.PADDR !== 32'h10 || bus.PWDATA !== 32'hDEADBEEF || bus.PSTRB !== 4'hF ||
                 bus.PWRITE !== 1'b1 || bus.PPROT !== 3'b010) begin fails++;
      $display("FAIL wr_fields: got addr=%h wdata=%h strb=%h wr=%0b prot=%h want 10/deadbeef/f/1/2",
               bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PWRITE, bus.PPROT); end
    tick();
    tests++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1 || bus.rsp_valid !== 1'b0 ||
                 bus.cmd_ready !== 1'b1) begin fails++;
      $display("FAIL wr_access: got psel=%0b pen=%0b v=%0b rdy=%0b want 1/1/0/1",
               bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready); end
    tick();
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_wait !== 8'd0 ||
                 bus.rsp_rdata !== 32'h0) begin fails++;
      $display("FAIL wr_rsp: got v=%0b err=%0b wait=%0d rdata=%h want 1/0/0/0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_wait, bus.rsp_rdata); end
    tests++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.PADDR !== 32'h10) begin fails++;
      $display("FAIL wr_idle: got psel=%0b pen=%0b addr=%h want 0/0/10", bus.PSEL, bus.PENABLE, bus.PADDR); end
    tick();
    tests++; if (bus.rsp_valid !== 1'b0) begin fails++;
      $display("FAIL wr_pulse: got rsp_valid=%0b want 0", bus.rsp_valid); end
  endtask

  task automatic test_read_waits();
    int bad;
    bad = 0;
    bus.PREADY = 1'b0;
    drive_cmd(1'b0, 32'h20, 32'hFFFFFFFF, 4'hF, 3'b001);
    tick();
    bus.cmd_valid = 1'b0;
    tests++; if (bus.PWRITE !== 1'b0 || bus.PWDATA !== 32'h0 || bus.PSTRB !== 4'h0) begin fails++;
      $display("FAIL rd_setup: got wr=%0b wdata=%h strb=%h want 0/0/0", bus.PWRITE, bus.PWDATA, bus.PSTRB); end
    tick();
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'h0BADF00D;
    for (int i = 0; i < 3; i++) begin
      if (bus.PENABLE !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
          bus.PSTRB !== 4'h0 || bus.PWDATA !== 32'h0) bad++;
      tick();
    end
    tests++; if (bad !== 0) begin fails++;
      $display("FAIL rd_wait_phase: got %0d bad wait cycles want 0", bad); end
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = 32'h12345678;
    tick();
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h12345678 || bus.rsp_wait !== 8'd3 ||
                 bus.rsp_err !== 1'b0) begin fails++;
      $display("FAIL rd_rsp: got v=%0b rdata=%h wait=%0d err=%0b want 1/12345678/3/0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_wait, bus.rsp_err); end
    tick();
    tests++; if (bus.rsp_rdata !== 32'h12345678 || bus.rsp_wait !== 8'd3) begin fails++;
      $display("FAIL rd_hold: got rdata=%h wait=%0d want 12345678/3", bus.rsp_rdata, bus.rsp_wait); end
  endtask

  task automatic test_back_to_back();
    bus.PREADY = 1'b1;
    drive_cmd(1'b1, 32'h30, 32'h11111111, 4'h3, 3'b000);
    tick();
    drive_cmd(1'b0, 32'h34, 32'h22222222, 4'hC, 3'b000);
    tick();
    tests++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1 || bus.PADDR !== 32'h30 ||
                 bus.cmd_ready !== 1'b1) begin fails++;
      $display("FAIL b2b_access1: got psel=%0b pen=%0b addr=%h rdy=%0b want 1/1/30/1",
               bus.PSEL, bus.PENABLE, bus.PADDR, bus.cmd_ready); end
    tick();
    bus.cmd_valid = 1'b0;
    bus.PRDATA    = 32'hCAFEF00D;
    tests++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0 || bus.PADDR !== 32'h34 ||
                 bus.PWRITE !== 1'b0 || bus.rsp_valid !== 1'b1) begin fails++;
      $display("FAIL b2b_setup2: got psel=%0b pen=%0b addr=%h wr=%0b v=%0b want 1/0/34/0/1",
               bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.rsp_valid); end
    tick();
    tests++; if (bus.PENABLE !== 1'b1 || bus.rsp_valid !== 1'b0) begin fails++;
      $display("FAIL b2b_access2: got pen=%0b v=%0b want 1/0", bus.PENABLE, bus.rsp_valid); end
    tick();
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hCAFEF00D || bus.PSEL !== 1'b0) begin fails++;
      $display("FAIL b2b_rsp2: got v=%0b rdata=%h psel=%0b want 1/cafef00d/0",
               bus.rsp_valid, bus.rsp_rdata, bus.PSEL); end
  endtask

  task automatic test_slave_error();
    bus.PREADY = 1'b1;
    drive_cmd(1'b1, 32'h40, 32'h55, 4'h1, 3'b000);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.PSLVERR = 1'b1;
    tick();
    bus.PSLVERR = 1'b0;
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1) begin fails++;
      $display("FAIL err_rsp: got v=%0b err=%0b want 1/1", bus.rsp_valid, bus.rsp_err); end
    tick();
    tests++; if (bus.rsp_err !== 1'b1) begin fails++;
      $display("FAIL err_hold: got err=%0b want 1", bus.rsp_err); end
    drive_cmd(1'b1, 32'h44, 32'h66, 4'h1, 3'b000);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin fails++;
      $display("FAIL err_clear: got v=%0b err=%0b want 1/0", bus.rsp_valid, bus.rsp_err); end
  endtask

  task automatic test_saturation();
    int unstable;
    unstable = 0;
    bus.PREADY = 1'b0;
    drive_cmd(1'b0, 32'h50, 32'h0, 4'h0, 3'b101);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) begin
      if (bus.PADDR !== 32'h50 || bus.PWRITE !== 1'b0 || bus.PPROT !== 3'b101 ||
          bus.PENABLE !== 1'b1 || bus.rsp_valid !== 1'b0) unstable++;
      tick();
    end
    tests++; if (unstable !== 0) begin fails++;
      $display("FAIL sat_stable: got %0d unstable cycles want 0", unstable); end
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h00C0FFEE;
    tick();
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_wait !== 8'd255 || bus.rsp_rdata !== 32'h00C0FFEE) begin fails++;
      $display("FAIL sat_rsp: got v=%0b wait=%0d rdata=%h want 1/255/00c0ffee",
               bus.rsp_valid, bus.rsp_wait, bus.rsp_rdata); end
  endtask

  task automatic test_reset_mid();
    bus.PREADY = 1'b0;
    drive_cmd(1'b1, 32'h60, 32'h77, 4'hF, 3'b011);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    PRESET     = 1'b1;
    bus.PREADY = 1'b1;
    tick();
    tests++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.PADDR !== 32'h0 ||
                 bus.PWDATA !== 32'h0 || bus.PPROT !== 3'h0) begin fails++;
      $display("FAIL rstmid_apb: got psel=%0b pen=%0b addr=%h wdata=%h prot=%h want all 0",
               bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA, bus.PPROT); end
    tests++; if (bus.rsp_valid !== 1'b0 || bus.rsp_wait !== 8'd0 || bus.rsp_rdata !== 32'h0 ||
                 bus.cmd_ready !== 1'b0) begin fails++;
      $display("FAIL rstmid_rsp: got v=%0b wait=%0d rdata=%h rdy=%0b want 0/0/0/0",
               bus.rsp_valid, bus.rsp_wait, bus.rsp_rdata, bus.cmd_ready); end
    PRESET = 1'b0;
    tick();
    tests++; if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) begin fails++;
      $display("FAIL rstmid_quiet: got v=%0b psel=%0b want 0/0", bus.rsp_valid, bus.PSEL); end
    drive_cmd(1'b1, 32'h70, 32'h88, 4'h2, 3'b000);
    tick();
    bus.cmd_valid = 1'b0;
    tests++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0 || bus.PADDR !== 32'h70) begin fails++;
      $display("FAIL rstmid_setup: got psel=%0b pen=%0b addr=%h want 1/0/70", bus.PSEL, bus.PENABLE, bus.PADDR); end
    tick();
    tick();
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_wait !== 8'd0 || bus.rsp_err !== 1'b0) begin fails++;
      $display("FAIL rstmid_next: got v=%0b wait=%0d err=%0b want 1/0/0", bus.rsp_valid, bus.rsp_wait, bus.rsp_err); end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    PRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = '0;
    bus.PSLVERR   = 1'b0;
    @(negedge PCLK);
    test_reset();
    test_single_write();
    test_read_waits();
    test_back_to_back();
    test_slave_error();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
